// File: rtl/console_seq_pkg.sv
`default_nettype none
// ============================================================================
// Module      : console_seq_pkg
// Description : State encoding and default timing constants for the console
//               power-up/alignment sequencer.
// Revision    : 1.0 - initial release
// ============================================================================
package console_seq_pkg;

    localparam int unsigned c_STATE_W = 3;
    typedef logic [c_STATE_W-1:0] state_t;

    localparam state_t c_ST_IDLE      = 3'd0;
    localparam state_t c_ST_HOLD      = 3'd1;
    localparam state_t c_ST_WAIT_SYNC = 3'd2;
    localparam state_t c_ST_ALIGN     = 3'd3;
    localparam state_t c_ST_CPU_START = 3'd4;
    localparam state_t c_ST_RUNNING   = 3'd5;
    localparam state_t c_ST_FAULT     = 3'd6;

    localparam int unsigned c_DEF_CNT_W           = 24;
    localparam int unsigned c_DEF_HOLD_CYCLES     = 1024;
    localparam int unsigned c_DEF_SYNC_TIMEOUT    = 1048576;
    localparam int unsigned c_DEF_ALIGN_DELAY     = 4;
    localparam int unsigned c_DEF_CPU_RESET_DELAY = 8;

endpackage
`default_nettype wire

// File: rtl/sync_fall_detect.sv
`default_nettype none
// ============================================================================
// Module      : sync_fall_detect
// Description : Two-flop synchronizer for an asynchronous active-low input,
//               followed by a one-cycle falling-edge pulse.
// Revision    : 1.0 - initial release
// ============================================================================
module sync_fall_detect (
    input  logic clkin,
    input  logic reset,
    input  logic async_n,
    output logic fall
);

    logic r_meta;
    logic r_sync;
    logic r_prev;

    // Idle-high reset values so a pin already low at release reads as a fresh edge.
    always_ff @(posedge clkin) begin
        if (reset) begin
            r_meta <= 1'b1;
            r_sync <= 1'b1;
            r_prev <= 1'b1;
        end else begin
            r_meta <= async_n;
            r_sync <= r_meta;
            r_prev <= r_sync;
        end
    end

    assign fall = r_prev & ~r_sync;

endmodule
`default_nettype wire

// File: rtl/console_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : console_sequencer
// Description : Power-up and APU/CPU clock alignment controller driving the
//               divider enables and active-low reset levels.
// Revision    : 1.0 - initial release
// ============================================================================
module console_sequencer
    import console_seq_pkg::*;
#(
    parameter int unsigned CNT_W           = c_DEF_CNT_W,
    parameter int unsigned HOLD_CYCLES     = c_DEF_HOLD_CYCLES,
    parameter int unsigned SYNC_TIMEOUT    = c_DEF_SYNC_TIMEOUT,
    parameter int unsigned ALIGN_DELAY     = c_DEF_ALIGN_DELAY,
    parameter int unsigned CPU_RESET_DELAY = c_DEF_CPU_RESET_DELAY
) (
    input  logic       clkin,
    input  logic       reset,
    input  logic       start,
    input  logic       abort,
    input  logic       apusync_n,
    input  logic       apu_phase0,
    output logic       apu_div_en,
    output logic       cpu_div_en,
    output logic       apu_reset_n,
    output logic       cpu_reset_n,
    output logic       running,
    output logic       fault,
    output logic [2:0] state_o
);

    generate
        if (((HOLD_CYCLES >> CNT_W) != 0) || ((SYNC_TIMEOUT >> CNT_W) != 0) ||
            ((ALIGN_DELAY >> CNT_W) != 0) || ((CPU_RESET_DELAY >> CNT_W) != 0) ||
            (HOLD_CYCLES == 0) || (SYNC_TIMEOUT == 0) || (CPU_RESET_DELAY == 0)) begin : g_param_check
            $error("console_sequencer: timing parameter out of range for CNT_W");
        end
    endgenerate

    localparam logic [CNT_W-1:0] c_HOLD_LAST  = CNT_W'(HOLD_CYCLES - 1);
    localparam logic [CNT_W-1:0] c_SYNC_LAST  = CNT_W'(SYNC_TIMEOUT - 1);
    localparam logic [CNT_W-1:0] c_ALIGN_LAST = (ALIGN_DELAY == 0) ? '0 : CNT_W'(ALIGN_DELAY - 1);
    localparam logic [CNT_W-1:0] c_CPU_LAST   = CNT_W'(CPU_RESET_DELAY - 1);

    state_t           r_state;
    logic [CNT_W-1:0] r_cnt;
    logic             r_armed;

    state_t           w_next_state;
    logic [CNT_W-1:0] w_next_cnt;
    logic [CNT_W-1:0] w_cnt_inc;
    logic             w_next_armed;
    logic             w_sync_fall;

    sync_fall_detect u_sync (
        .clkin   (clkin),
        .reset   (reset),
        .async_n (apusync_n),
        .fall    (w_sync_fall)
    );

    assign w_cnt_inc = (r_cnt == '1) ? r_cnt : r_cnt + 1'b1;

    always_comb begin
        w_next_state = r_state;
        w_next_cnt   = w_cnt_inc;
        w_next_armed = r_armed;
        if (abort) begin
            w_next_state = c_ST_IDLE;
            w_next_cnt   = '0;
            w_next_armed = 1'b0;
        end else begin
            case (r_state)
                c_ST_IDLE, c_ST_FAULT: begin
                    w_next_cnt = '0;
                    if (start) begin
                        w_next_state = c_ST_HOLD;
                    end
                end
                c_ST_HOLD: begin
                    if (r_cnt == c_HOLD_LAST) begin
                        w_next_state = c_ST_WAIT_SYNC;
                        w_next_cnt   = '0;
                    end
                end
                c_ST_WAIT_SYNC: begin
                    // An edge on the last timeout cycle still counts as success.
                    if (w_sync_fall) begin
                        w_next_state = c_ST_ALIGN;
                        w_next_cnt   = '0;
                        w_next_armed = 1'b0;
                    end else if (r_cnt == c_SYNC_LAST) begin
                        w_next_state = c_ST_FAULT;
                        w_next_cnt   = '0;
                    end
                end
                c_ST_ALIGN: begin
                    if (!r_armed) begin
                        w_next_cnt = '0;
                        if (apu_phase0) begin
                            if (ALIGN_DELAY == 0) begin
                                w_next_state = c_ST_CPU_START;
                            end else begin
                                w_next_armed = 1'b1;
                            end
                        end
                    end else if (r_cnt == c_ALIGN_LAST) begin
                        w_next_state = c_ST_CPU_START;
                        w_next_cnt   = '0;
                        w_next_armed = 1'b0;
                    end
                end
                c_ST_CPU_START: begin
                    if (r_cnt == c_CPU_LAST) begin
                        w_next_state = c_ST_RUNNING;
                        w_next_cnt   = '0;
                    end
                end
                c_ST_RUNNING: begin
                    w_next_cnt = '0;
                end
                default: begin
                    w_next_state = c_ST_IDLE;
                    w_next_cnt   = '0;
                    w_next_armed = 1'b0;
                end
            endcase
        end
    end

    // Outputs decode the next state so they change on the same edge as r_state.
    always_ff @(posedge clkin) begin
        if (reset) begin
            r_state     <= c_ST_IDLE;
            r_cnt       <= '0;
            r_armed     <= 1'b0;
            apu_div_en  <= 1'b0;
            cpu_div_en  <= 1'b0;
            apu_reset_n <= 1'b0;
            cpu_reset_n <= 1'b0;
            running     <= 1'b0;
            fault       <= 1'b0;
        end else begin
            r_state     <= w_next_state;
            r_cnt       <= w_next_cnt;
            r_armed     <= w_next_armed;
            apu_div_en  <= (w_next_state == c_ST_WAIT_SYNC) || (w_next_state == c_ST_ALIGN) ||
                           (w_next_state == c_ST_CPU_START) || (w_next_state == c_ST_RUNNING);
            apu_reset_n <= (w_next_state == c_ST_WAIT_SYNC) || (w_next_state == c_ST_ALIGN) ||
                           (w_next_state == c_ST_CPU_START) || (w_next_state == c_ST_RUNNING);
            cpu_div_en  <= (w_next_state == c_ST_CPU_START) || (w_next_state == c_ST_RUNNING);
            cpu_reset_n <= (w_next_state == c_ST_RUNNING);
            running     <= (w_next_state == c_ST_RUNNING);
            fault       <= (w_next_state == c_ST_FAULT);
        end
    end

    assign state_o = r_state;

endmodule
`default_nettype wire

// File: doc/console_sequencer.md
Name: console_sequencer

Overview:
- Power-up and alignment controller for the master-clock-domain console clock/reset outputs.
- Holds APU and CPU in reset, then releases the APU and enables its clock divider.
- Waits for the APU sync pulse, aligns to the APU divider phase, then enables the CPU divider and releases CPU reset after a fixed delay.
- Sits between the PLL-clocked divider instances and the reset/sync pins; drives only enables and active-low reset levels, never the clocks themselves.

Parameters:
- CNT_W, 24, width of shared delay/timeout counter.
- HOLD_CYCLES, 1024, master cycles both resets held after start (>=1).
- SYNC_TIMEOUT, 1048576, master cycles allowed in WAIT_SYNC before fault (>=1).
- ALIGN_DELAY, 4, master cycles after first APU phase-0 strobe before CPU divider enable (0 allowed).
- CPU_RESET_DELAY, 8, master cycles of CPU clock running before CPU reset release (>=1).

Ports:
- clkin  in  1  master clock (PLL global output).
- reset  in  1  synchronous, active-high; returns block to IDLE.
- start  in  1  level/pulse; sampled in IDLE or FAULT to begin sequence.
- abort  in  1  sampled every cycle; forces IDLE.
- apusync_n  in  1  asynchronous active-low sync from APU.
- apu_phase0  in  1  one-cycle strobe from the APU divider on counter wrap.
- apu_div_en  out  1  enable for APU divide-by-7/8.
- cpu_div_en  out  1  enable for CPU divide-by-8.
- apu_reset_n  out  1  APU reset, active-low.
- cpu_reset_n  out  1  CPU reset, active-low.
- running  out  1  high in RUNNING.
- fault  out  1  high in FAULT.
- state_o  out  3  current state encoding.

Behaviour:
- Timing model:
  - All outputs registered; Moore; each output updates on the same edge as the state register.
  - On reset: state IDLE; all outputs 0; counter 0; sync flops 1.
- State encoding: IDLE=0, HOLD=1, WAIT_SYNC=2, ALIGN=3, CPU_START=4, RUNNING=5, FAULT=6; 7 unused and must go to IDLE.
- apusync_n handling:
  - Passes through a 2-FF synchronizer, then a falling-edge detect (prev=1, now=0).
  - sync_fall lags the pin by 2–3 cycles.
- IDLE:
  - Outputs all 0.
  - start=1 -> HOLD; counter cleared.
- HOLD:
  - Both resets low; dividers off.
  - Lasts exactly HOLD_CYCLES cycles (exit when counter==HOLD_CYCLES-1) -> WAIT_SYNC.
  - Entering WAIT_SYNC sets apu_reset_n=1 and apu_div_en=1; counter cleared.
- WAIT_SYNC:
  - sync_fall -> ALIGN.
  - counter==SYNC_TIMEOUT-1 without sync_fall -> FAULT.
  - If both occur in the same cycle, sync_fall wins.
  - Edges that occurred before WAIT_SYNC are ignored: the edge detector prev is refreshed continuously.
- ALIGN:
  - Waits for apu_phase0; a strobe in the first ALIGN cycle counts.
  - After the strobe, counts ALIGN_DELAY cycles, then -> CPU_START; ALIGN_DELAY=0 goes on the cycle after the strobe.
  - Strobes during the delay count are ignored.
  - Entering CPU_START sets cpu_div_en=1.
- CPU_START:
  - Lasts CPU_RESET_DELAY cycles -> RUNNING.
  - Entering RUNNING sets cpu_reset_n=1 and running=1.
- RUNNING:
  - Holds all enables and reset releases; further sync edges and strobes are ignored.
- FAULT:
  - fault=1; resets low; both enables 0.
  - start -> HOLD (fault clears on entry).
- Priority:
  - reset > abort > start/normal transitions.
  - abort in any state -> IDLE next cycle with IDLE outputs.
  - abort+start together in IDLE: stays IDLE.
  - start in any state other than IDLE/FAULT is ignored.
- Counter:
  - Saturates at all-ones and never wraps.
  - Every parameter must fit in CNT_W bits (elaboration-time check).

Decomposition:
- Package console_seq_pkg: state enum/localparams (IDLE..FAULT), encoding width 3, parameter default constants.
- One sub-module, sync_fall_detect:
  - 2-FF synchronizer plus falling-edge pulse.
  - Ports clkin, reset, async_n, fall.
  - Flops reset to 1.

Test Plan:
Parameters for the bench: HOLD_CYCLES=16, SYNC_TIMEOUT=64, ALIGN_DELAY=3, CPU_RESET_DELAY=8.
1. Nominal:
   - Stimulus: start pulse at cycle 0; apusync_n low at cycle 30; apu_phase0 every 7 cycles.
   - Response: apu_reset_n rises at cycle 17; cpu_div_en rises 4 cycles after the first strobe seen in ALIGN; cpu_reset_n and running rise 8 cycles later.
2. Timeout:
   - Stimulus: start; apusync_n held high.
   - Response: state_o=6 and fault=1 exactly 64 cycles after entering WAIT_SYNC; all outputs 0 except fault. A second start gives state_o=1 with fault=0.
3. Abort mid-sequence:
   - Stimulus: abort during ALIGN and again during CPU_START.
   - Response: next cycle state_o=0 with all outputs 0. A restart re-runs the full 16-cycle HOLD.
4. Pre-armed sync:
   - Stimulus: apusync_n falls during HOLD and stays low.
   - Response: no ALIGN entry; timeout fault at 64 cycles.
5. Simultaneous events:
   - Stimulus: sync_fall on the final timeout cycle.
   - Response: state_o=3, no fault.
   - Stimulus: start and abort together in IDLE.
   - Response: state_o stays 0.
6. Synchronous reset:
   - Stimulus: reset asserted while in RUNNING.
   - Response: on the next edge all outputs 0 and state_o=0; start is ignored while reset is high.
